// File: rtl/axis_data_receiver.sv
// AXI-Stream slave: buffers DMA MM2S beats in a small FIFO and forwards them downstream.
// Frames longer than AXIS_DATA_DEPTH beats are cut; tkeep gaps are flagged but forwarded.
module axis_data_receiver #(
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int AXIS_DATA_KEEP  = 32,
  parameter int AXIS_DATA_DEPTH = 400,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0] AXIS_data_receiver_AXIS_tdata,
  input  logic [AXIS_DATA_KEEP-1:0]  AXIS_data_receiver_AXIS_tkeep,
  input  logic                       AXIS_data_receiver_AXIS_tlast,
  input  logic                       AXIS_data_receiver_AXIS_tvalid,
  output logic                       AXIS_data_receiver_AXIS_tready,
  output logic                       receive_vld,
  output logic [AXIS_DATA_WIDTH-1:0] receive_data,
  output logic                       receive_last,
  input  logic                       receive_rdy,
  output logic                       len_err,
  output logic                       keep_err,
  output logic [15:0]                frame_cnt
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(AXIS_DATA_DEPTH + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0]   beat_cnt_next;
  logic                last_out;
  logic                len_trunc;
  logic                keep_bad;
  logic                frame_done;

  logic [AXIS_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                       mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           count_next;
  logic                       tready_r;
  logic                       push;
  logic                       pop;

  // Both interfaces use the same rule: a transfer happens on a clock edge where
  // valid and ready are both high; valid never waits for ready, and ready is registered.
  assign AXIS_data_receiver_AXIS_tready = tready_r;
  assign push         = AXIS_data_receiver_AXIS_tvalid && tready_r;
  assign receive_vld  = (count != '0);
  assign pop          = receive_vld && receive_rdy;
  assign receive_data = mem_data[rd_ptr];
  assign receive_last = mem_last[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (!push && pop)
      count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tready_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      count    <= count_next;
      // Ready follows the next occupancy so a pop from full reopens the slot one cycle later.
      tready_r <= (count_next != CNT_W'(FIFO_DEPTH));
      if (push) begin
        mem_data[wr_ptr] <= AXIS_data_receiver_AXIS_tdata;
        mem_last[wr_ptr] <= last_out;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Frame tracker: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  // Frame tracker: next state
  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (push && !last_out) begin
          state_next    = ST_RECV;
          beat_cnt_next = BEAT_W'(1);
        end
      end
      ST_RECV: begin
        if (push) begin
          if (last_out) begin
            state_next    = ST_IDLE;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt + BEAT_W'(1);
          end
        end
      end
      default: begin
        state_next    = ST_IDLE;
        beat_cnt_next = '0;
      end
    endcase
  end

  // Frame tracker: outputs
  always_comb begin
    last_out   = AXIS_data_receiver_AXIS_tlast ||
                 (beat_cnt == BEAT_W'(AXIS_DATA_DEPTH - 1));
    len_trunc  = push && last_out && !AXIS_data_receiver_AXIS_tlast;
    keep_bad   = push && (AXIS_data_receiver_AXIS_tkeep != '1);
    frame_done = push && last_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_err   <= 1'b0;
      keep_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      len_err  <= len_trunc;
      keep_err <= keep_bad;
      if (frame_done)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_data_receiver.sv
// Directed and randomised checks for axis_data_receiver: latency, backpressure,
// length truncation, tkeep flagging, mid-frame reset and ordering.
module tb_axis_data_receiver;

  localparam int W     = 256;
  localparam int KW    = 32;
  localparam int DEPTH = 400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic          receive_vld;
  logic [W-1:0]  receive_data;
  logic          receive_last;
  logic          receive_rdy;
  logic          len_err;
  logic          keep_err;
  logic [15:0]   frame_cnt;

  axis_data_receiver dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .AXIS_data_receiver_AXIS_tdata  (tdata),
    .AXIS_data_receiver_AXIS_tkeep  (tkeep),
    .AXIS_data_receiver_AXIS_tlast  (tlast),
    .AXIS_data_receiver_AXIS_tvalid (tvalid),
    .AXIS_data_receiver_AXIS_tready (tready),
    .receive_vld                    (receive_vld),
    .receive_data                   (receive_data),
    .receive_last                   (receive_last),
    .receive_rdy                    (receive_rdy),
    .len_err                        (len_err),
    .keep_err                       (keep_err),
    .frame_cnt                      (frame_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];
  int         acc_cyc_q[$];
  int         out_cyc_q[$];
  int         model_cnt   = 0;
  int         exp_frames  = 0;
  int         exp_len_at  = -1;
  int         exp_keep_at = -1;
  int         n_acc = 0;
  int         n_out = 0;
  int         len_seen = 0;
  int         keep_seen = 0;
  int         rdy_mode = 0;
  logic       prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // downstream ready: 0 low, 1 high, 2 random
  initial begin
    receive_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       receive_rdy = 1'b0;
        1:       receive_rdy = 1'b1;
        default: receive_rdy = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // driver: hold the beat until it is accepted; call aligned to posedge+1
  task automatic drive_beat(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
    bit   acc = 1'b0;
    int   n = 0;
    logic lo;
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk);
      #1;
      n++;
    end
    tvalid = 1'b0;
    if (!acc) begin
      check("drv_timeout", 256'(0), 256'(1));
    end else begin
      lo = l || (model_cnt == DEPTH - 1);
      if (lo && !l) exp_len_at = cyc;
      if (k != '1) exp_keep_at = cyc;
      exp_q.push_back({lo, d});
      acc_cyc_q.push_back(cyc);
      n_acc++;
      if (lo) begin
        model_cnt = 0;
        exp_frames++;
      end else begin
        model_cnt++;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 256'(exp_q.size()), 256'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // scoreboard: compare each popped beat and every error pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && receive_vld) check("hold_data", receive_data, prev_data);
      if (receive_vld && receive_rdy) begin
        n_out++;
        out_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexp_beat", 256'(1), 256'(0));
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("out_data", receive_data, e[W-1:0]);
          check("out_last", 256'(receive_last), 256'(e[W]));
        end
      end
      if (len_err) len_seen++;
      if (keep_err) keep_seen++;
      if (len_err || exp_len_at == cyc)
        check("len_err", 256'(len_err), 256'(exp_len_at == cyc));
      if (keep_err || exp_keep_at == cyc)
        check("keep_err", 256'(keep_err), 256'(exp_keep_at == cyc));
      prev_stall = receive_vld && !receive_rdy;
      prev_data  = receive_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int base_acc;
    int base_len;
    int base_keep;
    logic [W-1:0] d;
    logic [KW-1:0] k;

    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tready", 256'(tready), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_tready_up", 256'(tready), 256'(1));
    check("rst_vld", 256'(receive_vld), 256'(0));
    check("rst_data", receive_data, 256'(0));
    check("rst_last", 256'(receive_last), 256'(0));
    check("rst_len", 256'(len_err), 256'(0));
    check("rst_keep", 256'(keep_err), 256'(0));
    check("rst_frames", 256'(frame_cnt), 256'(0));
    @(posedge clk); #1;

    // single 3-beat frame, no backpressure
    rdy_mode = 1;
    @(posedge clk); #1;
    acc_cyc_q.delete(); out_cyc_q.delete();
    drive_beat(256'h11, '1, 1'b0);
    drive_beat(256'h22, '1, 1'b0);
    drive_beat(256'h33, '1, 1'b1);
    wait_drain();
    check("t1_acc_b2", 256'(acc_cyc_q[1] - acc_cyc_q[0]), 256'(1));
    check("t1_acc_b3", 256'(acc_cyc_q[2] - acc_cyc_q[0]), 256'(2));
    for (int i = 0; i < 3; i++) check("t1_latency", 256'(out_cyc_q[i]), 256'(acc_cyc_q[i]));
    check("t1_frames", 256'(frame_cnt), 256'(1));
    check("t1_no_err", 256'(len_seen + keep_seen), 256'(0));

    // backpressure fill and drain
    rdy_mode = 0;
    @(posedge clk); #1;
    base_acc = n_acc;
    fork
      begin
        for (int i = 0; i < 6; i++) drive_beat(256'hA0 + 256'(i), '1, (i == 5));
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        check("bp_accepted", 256'(n_acc - base_acc), 256'(4));
        @(negedge clk);
        check("bp_tready", 256'(tready), 256'(0));
        check("bp_vld", 256'(receive_vld), 256'(1));
        check("bp_head", receive_data, 256'hA0);
        @(posedge clk); #1;
        rdy_mode = 1;
        @(negedge clk);
        check("bp_tready_pop", 256'(tready), 256'(0));
        @(posedge clk);
        @(negedge clk);
        check("bp_tready_after", 256'(tready), 256'(1));
      end
    join
    wait_drain();
    check("bp_frames", 256'(frame_cnt), 256'(2));

    // 401-beat stream truncated at 400
    base_len = len_seen;
    for (int i = 0; i < 401; i++) drive_beat(256'h1000 + 256'(i), '1, (i == 400));
    wait_drain();
    check("ovf_len_pulses", 256'(len_seen - base_len), 256'(1));
    check("ovf_frames", 256'(frame_cnt), 256'(4));

    // tkeep gap on second beat
    base_keep = keep_seen;
    drive_beat(256'h5A5A, '1, 1'b0);
    drive_beat(256'hC3C3, 32'h0000FFFF, 1'b1);
    wait_drain();
    check("keep_pulses", 256'(keep_seen - base_keep), 256'(1));
    check("keep_frames", 256'(frame_cnt), 256'(5));

    // reset with a partial frame buffered
    rdy_mode = 0;
    @(posedge clk); #1;
    drive_beat(256'hB1, '1, 1'b0);
    drive_beat(256'hB2, '1, 1'b0);
    rdy_mode = 1;
    @(posedge clk); #1;
    rdy_mode = 0;
    rst_n = 1'b0;
    exp_q.delete(); model_cnt = 0; exp_frames = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_vld", 256'(receive_vld), 256'(0));
    check("mrst_frames", 256'(frame_cnt), 256'(0));
    check("mrst_tready", 256'(tready), 256'(0));
    @(posedge clk); #1;
    rdy_mode = 1;
    drive_beat(256'hF00D, '1, 1'b1);
    wait_drain();
    check("mrst_frames_new", 256'(frame_cnt), 256'(1));

    // random valid/ready over 1000 beats
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom();
      k = ($urandom_range(0, 15) == 0) ? KW'($urandom()) : '1;
      drive_beat(d, k, ($urandom_range(0, 7) == 0));
    end
    wait_drain();
    check("rnd_frames", 256'(frame_cnt), 256'(exp_frames[15:0]));
    check("rnd_count", 256'(n_out), 256'(n_acc - 1));
    check("rnd_queue_empty", 256'(exp_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_data_receiver.md
Name: axis_data_receiver

Overview:
- AXI-Stream slave that accepts beats from the PS DMA (MM2S) path and delivers them to PL logic over a simple vld/rdy/last interface.
- It is the receive counterpart to the PL-to-PS stream transmitter. It sits between the DMA stream port and the downstream processing blocks.
- It buffers beats in a small FIFO, tracks frame boundaries, enforces a maximum frame length and checks tkeep.

Parameters:
- AXIS_DATA_WIDTH, 256, tdata width in bits
- AXIS_DATA_KEEP, 32, tkeep width (AXIS_DATA_WIDTH/8)
- AXIS_DATA_DEPTH, 400, maximum beats per frame
- FIFO_DEPTH, 4, receive buffer entries (power of 2, ≥2)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- AXIS_data_receiver_AXIS_tdata  input  AXIS_DATA_WIDTH  stream data
- AXIS_data_receiver_AXIS_tkeep  input  AXIS_DATA_KEEP  byte enables
- AXIS_data_receiver_AXIS_tlast  input  1  end of frame
- AXIS_data_receiver_AXIS_tvalid  input  1  beat valid
- AXIS_data_receiver_AXIS_tready  output  1  beat accepted when high with tvalid
- receive_vld  output  1  downstream beat valid
- receive_data  output  AXIS_DATA_WIDTH  downstream beat data
- receive_last  output  1  downstream end of frame
- receive_rdy  input  1  downstream ready
- len_err  output  1  one-cycle pulse: frame truncated at AXIS_DATA_DEPTH
- keep_err  output  1  one-cycle pulse: accepted beat had tkeep not all-ones
- frame_cnt  output  16  completed frames, wraps at 65535->0

Behaviour:
- Reset values: tready=0 during reset and 1 the first cycle after; receive_vld=0; receive_data=0; receive_last=0; len_err=0; keep_err=0; frame_cnt=0. FIFO is empty, beat counter is 0, state is IDLE.
- Accept: a beat is accepted when tvalid && tready.
- tready: tready = (fifo count != FIFO_DEPTH). It is driven only from registers and never depends on tvalid.
- Push: each accepted beat pushes {tdata, last_out} into the FIFO.
- Pop: receive_vld = FIFO not empty. receive_data and receive_last present the head entry. The head is popped when receive_vld && receive_rdy.
- Latency: an accepted beat appears at the output on the next cycle when the FIFO was empty. There is no combinational tdata->receive_data path.
- Simultaneous push+pop: count is unchanged. With the FIFO full, tready=0, so no push occurs even if a pop happens that cycle. tready rises the cycle after the pop.
- Full sustained case: with receive_rdy held high and no backpressure, the block accepts one beat per cycle.
- beat_cnt: internal counter, width clog2(AXIS_DATA_DEPTH+1). It counts accepted beats in the current frame.
- last_out = tlast || (beat_cnt == AXIS_DATA_DEPTH-1).
- Frame length error: if last_out is set by the counter while tlast=0, len_err pulses in the cycle after acceptance. The forced last goes downstream, and remaining upstream beats are treated as a new frame.
- Frame state machine:
  - IDLE (beat_cnt=0): an accepted beat with last_out=0 moves to RECV and sets beat_cnt=1. An accepted beat with last_out=1 stays in IDLE.
  - RECV: each accepted beat increments beat_cnt. An accepted beat with last_out=1 returns to IDLE and clears beat_cnt.
- Frame completion: every accepted beat with last_out=1 increments frame_cnt, including single-beat and truncated frames. frame_cnt updates the cycle after acceptance.
- keep_err: pulses the cycle after acceptance of any beat whose tkeep != all-ones. The data is still forwarded unmodified.
- Output stability: while receive_vld=1 && receive_rdy=0, receive_data and receive_last hold stable.
- Reset mid-frame: takes effect at the next clk edge. It flushes the FIFO, clears beat_cnt, frame_cnt and state, and drops receive_vld immediately. No partial frame survives reset.
- Widths: beat_cnt never exceeds AXIS_DATA_DEPTH-1. frame_cnt is modulo 2^16.

Test Plan:
- Single frame, no backpressure: 3 beats (0x11, 0x22, 0x33), tlast on beat 3, receive_rdy=1. Expected: receive_vld for 3 consecutive cycles starting 1 cycle after the first accept, receive_last only with 0x33, frame_cnt=1, no errors.
- Backpressure fill: receive_rdy=0, tvalid=1 continuously. Expected: exactly 4 beats accepted, then tready=0 and receive_data holds beat 0. On raising receive_rdy, all beats drain in order, and tready returns 1 the cycle after the first pop.
- Length overflow: 401-beat stream with tlast only on beat 401, AXIS_DATA_DEPTH=400. Expected: receive_last on beat 400, one len_err pulse, beat 401 delivered as a 1-beat frame with receive_last=1, frame_cnt=2.
- keep check: frame of 2 beats, beat 2 tkeep=0x0000FFFF. Expected: one keep_err pulse one cycle after beat 2 is accepted, data passes intact, frame_cnt increments.
- Reset mid-frame: 2 of 5 beats accepted and 1 still buffered when rst_n=0 for 1 cycle. Expected: receive_vld=0 and frame_cnt=0. A fresh 1-beat frame sent afterwards gives receive_last=1 and frame_cnt=1.
- Random tvalid/receive_rdy over 1000 beats. Expected: output sequence equals input sequence and each receive_last position equals its last_out, with no drops or duplicates.
